// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps all 16 input vectors onto a 4-input block, samples its f/f2 responses
// at the end of each hold and scores them against expected truth tables.
module exhaustive_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter logic [15:0] EXP_F       = 16'h0000,
  parameter logic [15:0] EXP_F2      = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       f,
  input  logic       f2,
  output logic       busy,
  output logic       done,
  output logic [4:0] err_count,
  output logic [3:0] first_err_idx,
  output logic       first_err_valid,
  output logic       pass
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_vec, w_vec_nxt;
  logic [7:0]  r_hold, w_hold_nxt;
  logic [4:0]  r_err, w_err_nxt;
  logic [3:0]  r_fidx, w_fidx_nxt;
  logic        r_fval, w_fval_nxt;
  logic        r_busy, r_done, r_pass;
  logic        w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic        w_sample, w_mis;

  assign w_sample = (r_hold == HOLD_LAST);
  assign w_mis    = (f != EXP_F[r_vec]) | (f2 != EXP_F2[r_vec]);

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_hold_nxt  = r_hold;
    w_err_nxt   = r_err;
    w_fidx_nxt  = r_fidx;
    w_fval_nxt  = r_fval;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_DRIVE;
          w_vec_nxt   = '0;
          w_hold_nxt  = '0;
          w_err_nxt   = '0;
          w_fidx_nxt  = '0;
          w_fval_nxt  = 1'b0;
        end
      end
      S_DRIVE: begin
        w_hold_nxt = r_hold + 8'd1;
        if (w_sample) begin
          if (w_mis) begin
            w_err_nxt = r_err + 5'd1;
            if (!r_fval) begin
              w_fidx_nxt = r_vec;
              w_fval_nxt = 1'b1;
            end
          end
          w_hold_nxt = '0;
          if (r_vec == 4'd15) begin
            w_state_nxt = S_DONE;
            w_vec_nxt   = '0;
          end else begin
            w_vec_nxt = r_vec + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Status flags are registered from the next state so every output is a flop.
    w_busy_nxt = (w_state_nxt == S_DRIVE);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pass_nxt = w_done_nxt && (w_err_nxt == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_hold  <= '0;
      r_err   <= '0;
      r_fidx  <= '0;
      r_fval  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= w_err_nxt;
      r_fidx  <= w_fidx_nxt;
      r_fval  <= w_fval_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // r_vec is forced to 0 outside DRIVE, so it drives a..d directly.
  assign {a, b, c, d}     = r_vec;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err_count        = r_err;
  assign first_err_idx    = r_fidx;
  assign first_err_valid  = r_fval;
  assign pass             = r_pass;

endmodule

// File: doc/exhaustive_vector_sequencer.md
# exhaustive_vector_sequencer

Self-checking stimulus/response stage for the 4-input, 2-output combinational blocks used in the lab exercises. It sequences all 16 input combinations onto `a,b,c,d`, holds each for a programmable number of clock cycles, and samples the block's `f`/`f2` responses at the end of each hold. Each sample is compared against parameterised expected truth tables, and the stage reports a mismatch count plus the first failing vector. It sits directly upstream of the block under test, which it drives, and directly downstream of it, since it consumes that block's outputs.

## Interface
- `HOLD_CYCLES`, 20: clock cycles each vector is driven; legal range 1..255.
- `EXP_F`, 16'h0000: expected `f`; bit `i` is the response to vector `{a,b,c,d} = i`.
- `EXP_F2`, 16'h0000: expected `f2`; same indexing as `EXP_F`.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins a sweep; ignored while `busy`.
- `a`, `b`, `c`, `d` output 1 each: drive vector; `a` is the MSB, `d` the LSB.
- `f`, `f2` input 1 each: responses from the block under test.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: high from sweep completion until the next `start` or `rst`.
- `err_count` output 5: number of vectors where `f` or `f2` mismatched; range 0..16.
- `first_err_idx` output 4: index of the first mismatching vector.
- `first_err_valid` output 1: `first_err_idx` is meaningful.
- `pass` output 1: equals `done & (err_count == 0)`.

## Operation
- States: IDLE, DRIVE, DONE.
- Internal registers:
  - `vec` [3:0] is the current vector.
  - `hold` [7:0] counts cycles within the current hold.
- IDLE:
  - `a..d` are 0.
  - On `start`, go to DRIVE with `vec=0` and `hold=0`.
  - The same edge clears `err_count`, `first_err_valid` and `first_err_idx`.
- DRIVE:
  - `{a,b,c,d}` equals `vec` at all times.
  - `hold` increments each cycle.
  - In the cycle where `hold == HOLD_CYCLES-1`, sample `f` and `f2`. A mismatch is `(f != EXP_F[vec]) | (f2 != EXP_F2[vec])`.
  - On a mismatch, `err_count` increments by 1. Both outputs wrong on the same vector still counts once.
  - On a mismatch with `first_err_valid == 0`, load `first_err_idx = vec` and set `first_err_valid`.
  - After that sample cycle: if `vec == 15`, go to DONE; otherwise increment `vec` and clear `hold`.
- DONE:
  - `a..d` are 0 and `done = 1`.
  - Results are held stable.
  - `start` clears the results and re-enters DRIVE exactly as from IDLE (restart).
- `err_count` cannot overflow: at most 16 increments into a 5-bit register.
- `start` while `busy` is ignored; the sweep is not restarted or extended.

## Timing
- Reset values, applied on the first rising edge with `rst` high, override all other activity:
  - state = IDLE
  - `a=b=c=d=0`
  - `busy=0`, `done=0`
  - `err_count=0`, `first_err_idx=0`, `first_err_valid=0`, `pass=0`
- Reset mid-sweep aborts immediately, leaves no partial `done`, and preserves no results.
- All outputs are registered. There is no combinational path from `f`/`f2` to any output.
- `start` sampled at edge N:
  - vector 0 appears and `busy=1` after edge N;
  - vector k appears after edge N + k·HOLD_CYCLES.
- Response sampling:
  - The sample for vector k uses `f`/`f2` in the last cycle of its hold.
  - This gives the block under test HOLD_CYCLES−1 cycles of settling.
  - The sample is compared at the edge ending that cycle.
- Completion:
  - `busy` falls and `done` rises after edge N + 16·HOLD_CYCLES.
  - Total latency from `start` to `done` is 16·HOLD_CYCLES cycles.
  - `err_count` already includes vector 15 at that point.
- With HOLD_CYCLES = 1, every DRIVE cycle is a sample cycle. The vector changes every cycle and the sweep lasts 16 cycles.

## Test plan
- **Reset values:** hold `rst` for 2 cycles. All outputs must be 0. Pulse `start` with `rst` held high: `busy` stays 0.
- **Clean sweep:** HOLD_CYCLES=20, EXP_F=16'hA5C3, EXP_F2=16'h0FF0, and a behavioural model returning exactly those tables. Pulse `start`. Required: `done=1` exactly 320 cycles later, `err_count=0`, `first_err_valid=0`, `pass=1`. Vectors must step 0..15 every 20 cycles, MSB on `a`.
- **Single fault:** as the clean sweep, but the model flips `f` on vector 5 and flips both `f` and `f2` on vector 9. Required: `err_count=2`, `first_err_idx=5`, `first_err_valid=1`, `pass=0`.
- **Total failure:** the model inverts `f` on every vector. Required: `err_count=16` (5'b10000) and `first_err_idx=0`.
- **Start during sweep:** pulse `start` at cycle 100 of a sweep. Required: no restart, and `done` is still at cycle 320.
- **Abort and restart:**
  - Assert `rst` for one cycle at cycle 150. Required: all outputs are 0 on the next cycle.
  - Start a new sweep. Required: it completes normally.
  - Pulse `start` from DONE. Required: results clear and a new 320-cycle sweep runs.
